feature_memory_ctrl: RTL

Sequencer for the triple-buffered feature memory, which holds three GRAPH_SIZE×GRAPH_SIZE buffers. It owns the write-buffer pointer, rotates it when the producer finishes a frame, and sweeps the two completed buffers out to the consumer with a ready/valid handshake. It then zero-cleans the oldest buffer so that buffer is empty when it becomes the next write target. It sits between the feature extractor (producer), the feature memory, and the downstream graph-convolution reader (consumer).

---
 rtl/graph_pkg.sv | 30 +++
 rtl/addr_sweep.sv | 48 ++++
 rtl/feature_memory_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/graph_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : graph_pkg
// Purpose  : Shared types and helpers for the graph feature-memory datapath.
//            fm_state_t - sequencer state encoding for feature_memory_ctrl
//            FM_NUM_BUFS - number of rotating feature buffers
//            next_ptr()  - modulo-3 buffer pointer increment
// Revision : 1.0 - initial release
// ============================================================================
package graph_pkg;

  typedef enum logic [1:0] {
    FM_IDLE  = 2'd0,
    FM_READ  = 2'd1,
    FM_CLEAN = 2'd2
  } fm_state_t;

  localparam int FM_NUM_BUFS = 3;

  // Wraps back to buffer 0 after the last buffer; pointer never leaves 0..2.
  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    if (ptr >= 2'(FM_NUM_BUFS - 1)) begin
      return 2'd0;
    end
    return ptr + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_sweep.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : addr_sweep
// Purpose  : Address counter for one full pass over a DEPTH-word buffer.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            start       - load count with 0 (wins over en)
//            en          - step the count by one
//            addr        - current address (low ADDR_WIDTH bits of count)
//            term        - count sits on the final address DEPTH-1
//            done        - final address is being stepped this cycle
// Revision : 1.0 - initial release
// ============================================================================
module addr_sweep #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  term,
  output logic                  done
);

  // One extra bit so that stepping past DEPTH-1 never aliases back onto a
  // valid address before the owner stops enabling the counter.
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  logic [ADDR_WIDTH:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign addr = count[ADDR_WIDTH-1:0];
  assign term = (count == LAST);
  assign done = en && term;

endmodule
`default_nettype wire

// File: rtl/feature_memory_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : feature_memory_ctrl
// Purpose  : Sequencer for the triple-buffered feature memory. Rotates the
//            write pointer on each finished frame, streams the completed
//            buffers to the consumer, then zero-cleans the oldest buffer.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            in_frame_done   - producer finished the current buffer (pulse)
//            in_ready        - producer may write / signal in_frame_done
//            mem_ptr         - write-buffer pointer to the memory (0..2)
//            mem_out_addr    - port-B address to the memory
//            mem_out_clean   - memory zero-clean strobe (blocks port-B reads)
//            cons_ready      - consumer requests the next word
//            rd_valid        - memory read data valid this cycle
//            rd_addr         - address of the word flagged by rd_valid
//            rd_last         - rd_valid word is the final address
//            frame_cnt       - rotations since reset (wraps)
//            overrun_err     - sticky: frame finished while not ready
// Revision : 1.0 - initial release
// ============================================================================
module feature_memory_ctrl
  import graph_pkg::*;
#(
  parameter int GRAPH_SIZE = 32,
  parameter int ADDR_WIDTH = $clog2(GRAPH_SIZE * GRAPH_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_frame_done,
  output logic                  in_ready,
  output logic [1:0]            mem_ptr,
  output logic [ADDR_WIDTH-1:0] mem_out_addr,
  output logic                  mem_out_clean,
  input  logic                  cons_ready,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_last,
  output logic [15:0]           frame_cnt,
  output logic                  overrun_err
);

  localparam int DEPTH = GRAPH_SIZE * GRAPH_SIZE;

  fm_state_t state;
  fm_state_t state_next;

  logic                  pending;
  logic                  rotate;
  logic                  rd_issue;
  logic                  clean_en;
  logic                  clean_out;
  logic [ADDR_WIDTH-1:0] rd_sweep_addr;
  logic                  rd_term;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] clean_addr;
  logic                  clean_term;
  logic                  clean_done;

  // Read sweep restarts from 0 on every rotation.
  addr_sweep #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_sweep (
    .clk   (clk),
    .reset (reset),
    .start (rotate),
    .en    (rd_issue),
    .addr  (rd_sweep_addr),
    .term  (rd_term),
    .done  (rd_done)
  );

  // Clean sweep is armed by the final read issue so it starts at 0 on the
  // first CLEAN cycle and advances once per cycle.
  addr_sweep #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clean_sweep (
    .clk   (clk),
    .reset (reset),
    .start (rd_done),
    .en    (clean_en),
    .addr  (clean_addr),
    .term  (clean_term),
    .done  (clean_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rotate     = 1'b0;
    rd_issue   = 1'b0;
    clean_en   = 1'b0;
    clean_out  = 1'b0;
    case (state)
      FM_IDLE: begin
        if (pending) begin
          rotate     = 1'b1;
          state_next = FM_READ;
        end
      end
      FM_READ: begin
        rd_issue = cons_ready;
        if (cons_ready && rd_term) begin
          state_next = FM_CLEAN;
        end
      end
      FM_CLEAN: begin
        clean_en  = 1'b1;
        clean_out = 1'b1;
        if (clean_term) begin
          state_next = FM_IDLE;
        end
      end
      default: state_next = FM_IDLE;
    endcase
  end

  assign in_ready      = !pending && (state == FM_IDLE);
  assign mem_out_clean = clean_out;
  // The clean pass walks the buffer on the same port-B address bus.
  assign mem_out_addr  = (state == FM_CLEAN) ? clean_addr : rd_sweep_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ptr     <= 2'd0;
      frame_cnt   <= 16'd0;
      pending     <= 1'b0;
      overrun_err <= 1'b0;
      rd_valid    <= 1'b0;
      rd_addr     <= '0;
      rd_last     <= 1'b0;
    end else begin
      // Port-B read data lags the issued address by one cycle.
      rd_valid <= rd_issue;
      rd_addr  <= rd_sweep_addr;
      rd_last  <= rd_issue && rd_term;

      // A pulse coinciding with rotation finds pending already set and is
      // dropped, which is the same rule as any pulse while pending.
      if (rotate) begin
        mem_ptr   <= next_ptr(mem_ptr);
        frame_cnt <= frame_cnt + 16'd1;
        pending   <= 1'b0;
      end else if (in_frame_done) begin
        pending <= 1'b1;
      end

      // The last CLEAN cycle hands the buffer back at the next edge, so a
      // frame finishing exactly then is on time and not an overrun.
      if (in_frame_done &&
          (pending || ((state != FM_IDLE) && !clean_done))) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
